// File: rtl/bit_shift_pkg.sv
// Shared types for the pipelined right shifter: operation encoding, defaults, payload layout.
// Rotate support is compiled in with BIT_SHIFT_RIGHT_ROTATE_EN.
package bit_shift_pkg;

    typedef enum logic [1:0] {
        SHR_LOGICAL = 2'd0,
        SHR_ARITH   = 2'd1,
        SHR_ROTATE  = 2'd2,
        SHR_RSVD    = 2'd3
    } shift_op_t;

    localparam int DEFAULT_SHIFT_WIDTH = 32;
    localparam int DEFAULT_TAG_WIDTH   = 4;
    localparam int DEFAULT_AMT_W       = $clog2(DEFAULT_SHIFT_WIDTH);

    typedef struct packed {
        logic [DEFAULT_SHIFT_WIDTH-1:0] data;
        logic [DEFAULT_AMT_W-1:0]       amount;
        logic                           fill;
        shift_op_t                      op;
        logic [DEFAULT_TAG_WIDTH-1:0]   tag;
    } shift_payload_t;

    // Only arithmetic shifts replicate the sign; rotate and reserved fall back to zero fill.
    function automatic logic fill_bit(input shift_op_t op, input logic msb);
        logic f;
        case (op)
            SHR_ARITH: f = msb;
            default:   f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/bit_shift_right_stage.sv
// One conditional right-shift layer of AMOUNT bits followed by the stage register.
// The rotate mux exists only with BIT_SHIFT_RIGHT_ROTATE_EN defined.
module bit_shift_right_stage
    import bit_shift_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_SHIFT_WIDTH,
    parameter int AMOUNT    = 1,
    parameter int AMT_W     = $clog2(WIDTH),
    parameter int TAG_WIDTH = DEFAULT_TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adv,
    input  logic                 up_valid,
    input  logic [WIDTH-1:0]     up_data,
    input  logic [AMT_W-1:0]     up_amount,
    input  logic                 up_fill,
    input  shift_op_t            up_op,
    input  logic [TAG_WIDTH-1:0] up_tag,
    output logic                 valid_q,
    output logic [WIDTH-1:0]     data_q,
    output logic [AMT_W-1:0]     amount_q,
    output logic                 fill_q,
    output shift_op_t            op_q,
    output logic [TAG_WIDTH-1:0] tag_q
);

    localparam int BIT = $clog2(AMOUNT);

    logic [WIDTH-1:0]     shifted_s;
    logic                 valid_d;
    logic [WIDTH-1:0]     data_d;
    logic [AMT_W-1:0]     amount_d;
    logic                 fill_d;
    shift_op_t            op_d;
    logic [TAG_WIDTH-1:0] tag_d;

    // Shift layer selected by this stage's amount bit.
    always_comb begin
        shifted_s = up_data;
        if (up_amount[BIT]) begin
`ifdef BIT_SHIFT_RIGHT_ROTATE_EN
            if (up_op == SHR_ROTATE) begin
                shifted_s = {up_data[AMOUNT-1:0], up_data[WIDTH-1:AMOUNT]};
            end else begin
                shifted_s = {{AMOUNT{up_fill}}, up_data[WIDTH-1:AMOUNT]};
            end
`else
            shifted_s = {{AMOUNT{up_fill}}, up_data[WIDTH-1:AMOUNT]};
`endif
        end else begin
            shifted_s = up_data;
        end
    end

    // Advance: take the upstream item (or a bubble) when ready, otherwise hold.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        amount_d = amount_q;
        fill_d   = fill_q;
        op_d     = op_q;
        tag_d    = tag_q;
        if (adv && up_valid) begin
            valid_d  = 1'b1;
            data_d   = shifted_s;
            amount_d = up_amount;
            fill_d   = up_fill;
            op_d     = up_op;
            tag_d    = up_tag;
        end else if (adv) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= {WIDTH{1'b0}};
            amount_q <= {AMT_W{1'b0}};
            fill_q   <= 1'b0;
            op_q     <= SHR_LOGICAL;
            tag_q    <= {TAG_WIDTH{1'b0}};
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            amount_q <= amount_d;
            fill_q   <= fill_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
        end
    end

endmodule

// File: rtl/bit_shift_right_pipe.sv
// Pipelined barrel right shifter, one registered layer per amount bit, valid/ready on both ends.
// Define BIT_SHIFT_RIGHT_ROTATE_EN to build rotate-right; otherwise SHR_ROTATE acts as logical.
module bit_shift_right_pipe
    import bit_shift_pkg::*;
#(
    parameter  int WIDTH     = DEFAULT_SHIFT_WIDTH,
    parameter  int TAG_WIDTH = DEFAULT_TAG_WIDTH,
    localparam int AMT_W     = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [AMT_W-1:0]     in_amount,
    input  logic [1:0]           in_op,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [TAG_WIDTH-1:0] out_tag
);

    logic                 valid_s  [1:AMT_W];
    logic [WIDTH-1:0]     data_s   [1:AMT_W];
    logic [AMT_W-1:0]     amount_s [1:AMT_W];
    logic                 fill_s   [1:AMT_W];
    shift_op_t            op_s     [1:AMT_W];
    logic [TAG_WIDTH-1:0] tag_s    [1:AMT_W];
    logic [AMT_W:1]       rdy_s;
    shift_op_t            in_op_s;
    logic                 unused_s;

    assign in_op_s = shift_op_t'(in_op);

    // Ready chain from the output back to the input; any bubble lets upstream advance.
    always_comb begin
        rdy_s        = {AMT_W{1'b0}};
        rdy_s[AMT_W] = out_ready | ~valid_s[AMT_W];
        for (int k = AMT_W - 1; k >= 1; k--) begin
            rdy_s[k] = rdy_s[k+1] | ~valid_s[k];
        end
    end

    for (genvar k = 1; k <= AMT_W; k++) begin : g_stage
        logic                 up_valid_s;
        logic [WIDTH-1:0]     up_data_s;
        logic [AMT_W-1:0]     up_amount_s;
        logic                 up_fill_s;
        shift_op_t            up_op_s;
        logic [TAG_WIDTH-1:0] up_tag_s;

        if (k == 1) begin : g_first
            assign up_valid_s  = in_valid;
            assign up_data_s   = in_data;
            assign up_amount_s = in_amount;
            assign up_fill_s   = fill_bit(in_op_s, in_data[WIDTH-1]);
            assign up_op_s     = in_op_s;
            assign up_tag_s    = in_tag;
        end else begin : g_next
            assign up_valid_s  = valid_s[k-1];
            assign up_data_s   = data_s[k-1];
            assign up_amount_s = amount_s[k-1];
            assign up_fill_s   = fill_s[k-1];
            assign up_op_s     = op_s[k-1];
            assign up_tag_s    = tag_s[k-1];
        end

        bit_shift_right_stage #(
            .WIDTH     (WIDTH),
            .AMOUNT    (2 ** (k - 1)),
            .AMT_W     (AMT_W),
            .TAG_WIDTH (TAG_WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (rdy_s[k]),
            .up_valid  (up_valid_s),
            .up_data   (up_data_s),
            .up_amount (up_amount_s),
            .up_fill   (up_fill_s),
            .up_op     (up_op_s),
            .up_tag    (up_tag_s),
            .valid_q   (valid_s[k]),
            .data_q    (data_s[k]),
            .amount_q  (amount_s[k]),
            .fill_q    (fill_s[k]),
            .op_q      (op_s[k]),
            .tag_q     (tag_s[k])
        );
    end

    assign in_ready  = rdy_s[1];
    assign out_valid = valid_s[AMT_W];
    assign out_data  = data_s[AMT_W];
    assign out_tag   = tag_s[AMT_W];

    // The last stage's control payload has no consumer.
    assign unused_s = ^{amount_s[AMT_W], fill_s[AMT_W], op_s[AMT_W]};

endmodule

// File: tb/tb_bit_shift_right_pipe.sv
// Directed and scoreboarded bench for bit_shift_right_pipe (WIDTH=32, TAG_WIDTH=4).
// Expectations follow BIT_SHIFT_RIGHT_ROTATE_EN when it is defined for the build.
module tb_bit_shift_right_pipe;
    import bit_shift_pkg::*;

    localparam int WIDTH = 32;
    localparam int AMT_W = 5;

`ifdef BIT_SHIFT_RIGHT_ROTATE_EN
    localparam logic [31:0] ROT1_EXP  = 32'h8000_0000;
    localparam logic [31:0] ROT31_EXP = 32'h0000_0003;
    localparam logic [31:0] ROT8_EXP  = 32'h7812_3456;
`else
    localparam logic [31:0] ROT1_EXP  = 32'h0000_0000;
    localparam logic [31:0] ROT31_EXP = 32'h0000_0001;
    localparam logic [31:0] ROT8_EXP  = 32'h0012_3456;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amount;
    logic [1:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    int check_cnt = 0;
    int err_cnt   = 0;
    int acc_cnt   = 0;
    int out_cnt   = 0;
    logic [31:0] exp_data_q [$];
    logic [3:0]  exp_tag_q  [$];

    bit_shift_right_pipe #(.WIDTH(WIDTH), .TAG_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
        logic [31:0] r;
        case (op)
            2'd1: r = 32'($signed(d) >>> a);
`ifdef BIT_SHIFT_RIGHT_ROTATE_EN
            2'd2: r = (d >> a) | (d << (6'd32 - {1'b0, a}));
`endif
            default: r = d >> a;
        endcase
        return r;
    endfunction

    // Called just after a negedge with inputs settled: score the coming edge, then move to next negedge.
    task automatic tick();
        if (out_valid && out_ready) begin
            if (exp_data_q.size() == 0) begin
                check_val("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                check_val("sb_data", out_data, exp_data_q.pop_front());
                check_val("sb_tag", 32'(out_tag), 32'(exp_tag_q.pop_front()));
                out_cnt++;
            end
        end
        if (in_valid && in_ready) begin
            exp_data_q.push_back(ref_shift(in_data, in_amount, in_op));
            exp_tag_q.push_back(in_tag);
            acc_cnt++;
        end
        @(negedge clk);
    endtask

    // Single isolated operation with a hand-computed result; also measures latency.
    task automatic run_one(input string name, input logic [31:0] d, input logic [4:0] a,
                           input logic [1:0] op, input logic [3:0] t, input logic [31:0] exp);
        int lat;
        in_valid = 1'b1; in_data = d; in_amount = a; in_op = op; in_tag = t; out_ready = 1'b1;
        #1;
        check_val({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        #1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check_val({name, "_latency"}, 32'(lat), 32'(AMT_W - 1));
        check_val({name, "_data"}, out_data, exp);
        check_val({name, "_tag"}, 32'(out_tag), 32'(t));
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   nxt;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_amount = 5'd0;
        in_op = 2'd0; in_tag = 4'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", out_data, 32'd0);
        check_val("rst_out_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;
        #1;
        check_val("rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        run_one("logical",    32'h8000_00F0, 5'd4,  SHR_LOGICAL, 4'd3,  32'h0800_000F);
        run_one("arith_neg",  32'h8000_0000, 5'd31, SHR_ARITH,   4'd1,  32'hFFFF_FFFF);
        run_one("arith_pos",  32'h7FFF_FFFF, 5'd31, SHR_ARITH,   4'd2,  32'h0000_0000);
        run_one("logic_31",   32'h8000_0000, 5'd31, SHR_LOGICAL, 4'd4,  32'h0000_0001);
        run_one("arith_8",    32'hF000_0000, 5'd8,  SHR_ARITH,   4'd5,  32'hFFF0_0000);
        run_one("amt0_log",   32'hA5A5_5A5A, 5'd0,  SHR_LOGICAL, 4'd6,  32'hA5A5_5A5A);
        run_one("amt0_ari",   32'hA5A5_5A5A, 5'd0,  SHR_ARITH,   4'd7,  32'hA5A5_5A5A);
        run_one("amt0_rot",   32'hA5A5_5A5A, 5'd0,  SHR_ROTATE,  4'd8,  32'hA5A5_5A5A);
        run_one("reserved",   32'hF000_0000, 5'd4,  SHR_RSVD,    4'd9,  32'h0F00_0000);
        run_one("rotate_1",   32'h0000_0001, 5'd1,  SHR_ROTATE,  4'd10, ROT1_EXP);
        run_one("rotate_31",  32'h8000_0001, 5'd31, SHR_ROTATE,  4'd11, ROT31_EXP);
        run_one("rotate_8",   32'h1234_5678, 5'd8,  SHR_ROTATE,  4'd12, ROT8_EXP);

        // Back-to-back stream into a stalled output.
        out_cnt = 0; acc_cnt = 0; nxt = 0;
        for (int cyc = 0; cyc < 60 && out_cnt < 8; cyc++) begin
            in_valid  = (nxt < 8);
            in_data   = 32'hFFFF_FFFF;
            in_amount = nxt[4:0];
            in_op     = SHR_LOGICAL;
            in_tag    = nxt[3:0];
            out_ready = (cyc >= 7);
            #1;
            if (cyc == 5 || cyc == 6) begin
                check_val("stall_in_ready", 32'(in_ready), 32'd0);
                check_val("stall_out_valid", 32'(out_valid), 32'd1);
                check_val("stall_out_data", out_data, 32'hFFFF_FFFF);
            end
            if (cyc == 7) check_val("stall_accepted", 32'(acc_cnt), 32'd5);
            acc = in_valid && in_ready;
            tick();
            if (acc) nxt++;
        end
        check_val("stall_out_cnt", 32'(out_cnt), 32'd8);

        // Reset while operations are in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h1234_5678 + 32'(i); in_amount = 5'd0;
            in_op = SHR_LOGICAL; in_tag = 4'd7;
            #1;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tick();
        end
        #1;
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_data", out_data, 32'd0);
        check_val("mid_rst_tag", 32'(out_tag), 32'd0);
        exp_data_q.delete();
        exp_tag_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check_val("post_rst_ready", 32'(in_ready), 32'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            check_val("no_stale", 32'(out_valid), 32'd0);
            tick();
        end

        // Random traffic against the reference model with random backpressure.
        out_cnt = 0; acc_cnt = 0; acc = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!in_valid || acc) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = $urandom;
                in_amount = 5'($urandom_range(0, 31));
                in_op     = 2'($urandom_range(0, 3));
                in_tag    = 4'($urandom_range(0, 15));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_valid && in_ready;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_data_q.size() != 0; i++) begin
            #1;
            tick();
        end
        check_val("drain_empty", 32'(exp_data_q.size()), 32'd0);
        check_val("rand_count", 32'(out_cnt), 32'(acc_cnt));

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
